// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO; 32-step shift-add / restoring divide.
// Define MULDIV_MADD_EN to enable MADD/MADDU accumulate into {hi,lo}.
module muldiv_unit #(
  parameter int WIDTH  = 32,
  parameter int CYCLES = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MULDIV_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MADDU = 3'b111;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] acc_q;
  logic [W-1:0]   m_q;
  logic           is_div_q;
  logic           neg_q;
  logic           rneg_q;
`ifdef MULDIV_MADD_EN
  logic           madd_q;
  logic           is_madd;
`endif

  logic           accept;
  logic           go_run;
  logic           wr_hi;
  logic           wr_lo;
  logic           dz;
  logic           sgn;
  logic           is_div;
  logic           sa;
  logic           sb;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;

  logic [W:0]     sum;
  logic [W:0]     shl;
  logic [W:0]     diff;
  logic [2*W-1:0] step;
  logic [2*W-1:0] prod;
  logic [W-1:0]   q_fix;
  logic [W-1:0]   r_fix;
  logic [2*W-1:0] res;

  assign busy   = (state_q == RUN);
  assign accept = (state_q == IDLE) && start;

  always_comb begin
    go_run = 1'b0;
    wr_hi  = 1'b0;
    wr_lo  = 1'b0;
    dz     = 1'b0;
    sgn    = 1'b0;
    is_div = 1'b0;
`ifdef MULDIV_MADD_EN
    is_madd = 1'b0;
`endif
    unique case (op)
      OP_MULT: begin
        go_run = 1'b1;
        sgn    = 1'b1;
      end
      OP_MULTU: go_run = 1'b1;
      OP_DIV: begin
        sgn    = 1'b1;
        is_div = 1'b1;
        dz     = (srcB == '0);
        go_run = (srcB != '0);
      end
      OP_DIVU: begin
        is_div = 1'b1;
        dz     = (srcB == '0);
        go_run = (srcB != '0);
      end
      OP_MTHI: wr_hi = 1'b1;
      OP_MTLO: wr_lo = 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MADD: begin
        go_run  = 1'b1;
        sgn     = 1'b1;
        is_madd = 1'b1;
      end
      OP_MADDU: begin
        go_run  = 1'b1;
        is_madd = 1'b1;
      end
`else
      default: ;
`endif
    endcase
  end

  // Iterate on magnitudes; the sign is restored at commit.
  always_comb begin
    sa    = sgn & srcA[W-1];
    sb    = sgn & srcB[W-1];
    mag_a = sa ? (-srcA) : srcA;
    mag_b = sb ? (-srcB) : srcB;
  end

  always_comb begin
    sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, m_q} : '0);
    shl  = {acc_q[2*W-1:W], acc_q[W-1]};
    diff = shl - {1'b0, m_q};
    if (!is_div_q)
      step = {sum, acc_q[W-1:1]};
    else if (diff[W])
      step = {acc_q[2*W-2:0], 1'b0};
    else
      step = {diff[W-1:0], acc_q[W-2:0], 1'b1};
  end

  always_comb begin
    prod  = neg_q ? (-step) : step;
    q_fix = neg_q ? (-step[W-1:0]) : step[W-1:0];
    r_fix = rneg_q ? (-step[2*W-1:W]) : step[2*W-1:W];
    res   = is_div_q ? {r_fix, q_fix} : prod;
`ifdef MULDIV_MADD_EN
    if (madd_q)
      res = {hi, lo} + prod;
`endif
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && go_run) state_d = RUN;
      RUN:  if (cnt_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      divByZero <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      m_q       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
`ifdef MULDIV_MADD_EN
      madd_q    <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
      divByZero <= 1'b0;
      if (accept) begin
        if (wr_hi) hi <= srcA;
        if (wr_lo) lo <= srcA;
        if (!go_run) begin
          done      <= 1'b1;
          divByZero <= dz;
        end
        cnt_q    <= '0;
        is_div_q <= is_div;
        neg_q    <= sa ^ sb;
        rneg_q   <= sa;
        m_q      <= is_div ? mag_b : mag_a;
        acc_q    <= {{W{1'b0}}, (is_div ? mag_a : mag_b)};
`ifdef MULDIV_MADD_EN
        madd_q   <= is_madd;
`endif
      end else if (state_q == RUN) begin
        acc_q <= step;
        if (cnt_q == LAST) begin
          cnt_q <= '0;
          hi    <= res[2*W-1:W];
          lo    <= res[W-1:0];
          done  <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: plain-arithmetic HI/LO model,
// directed corner cases then randomized ops.
module tb_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        busy;
  logic        done;
  logic        divByZero;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_unit #(.WIDTH(32), .CYCLES(32)) dut (
    .CLK(CLK),
    .RESETn(RESETn),
    .start(start),
    .op(op),
    .srcA(srcA),
    .srcB(srcB),
    .busy(busy),
    .done(done),
    .divByZero(divByZero),
    .hi(hi),
    .lo(lo)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (RESETn && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("hi", 64'(hi), 64'(mon_e.hi));
        chk("lo", 64'(lo), 64'(mon_e.lo));
        chk("divByZero", 64'(divByZero), 64'(mon_e.dz));
        chk("latency", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic scramble();
    op   = 3'($urandom);
    srcA = $urandom;
    srcB = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge CLK);
      #1;
      scramble();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout at cycle %0d", cyc);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    exp_t        e;
    longint      la;
    longint      lb;
    longint      q;
    longint      r;
    logic [63:0] p;
    bit          run;
    wait_idle();
    run  = 1'b0;
    e.dz = 1'b0;
    case (o)
      3'd0: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        {mhi, mlo} = p;
        run = 1'b1;
      end
      3'd1: begin
        p = {32'b0, a} * {32'b0, b};
        {mhi, mlo} = p;
        run = 1'b1;
      end
      3'd2: begin
        if (b == 0) begin
          e.dz = 1'b1;
        end else begin
          la  = longint'($signed(a));
          lb  = longint'($signed(b));
          q   = la / lb;
          r   = la % lb;
          mlo = q[31:0];
          mhi = r[31:0];
          run = 1'b1;
        end
      end
      3'd3: begin
        if (b == 0) begin
          e.dz = 1'b1;
        end else begin
          mlo = a / b;
          mhi = a % b;
          run = 1'b1;
        end
      end
      3'd4: mhi = a;
      3'd5: mlo = a;
`ifdef MULDIV_MADD_EN
      3'd6: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        {mhi, mlo} = {mhi, mlo} + p;
        run = 1'b1;
      end
      3'd7: begin
        p = {32'b0, a} * {32'b0, b};
        {mhi, mlo} = {mhi, mlo} + p;
        run = 1'b1;
      end
`endif
      default: ;
    endcase
    e.hi  = mhi;
    e.lo  = mlo;
    e.cyc = cyc + (run ? 33 : 1);
    sb.push_back(e);
    op    = o;
    srcA  = a;
    srcB  = b;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    scramble();
    chk("busy_after_accept", 64'(busy), 64'(run));
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'h0000_0001;
      4: v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int n;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_hi", 64'(hi), 64'h0);
    chk("reset_lo", 64'(lo), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_done", 64'(done), 64'h0);
    chk("reset_dz", 64'(divByZero), 64'h0);
    RESETn = 1'b1;
    @(posedge CLK);
    #1;

    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd4, 32'h0000_1234, 32'd0);
    issue(3'd5, 32'h0000_5678, 32'd0);
    issue(3'd3, 32'h0000_0009, 32'd0);
    issue(3'd2, 32'h0000_0009, 32'd0);

    issue(3'd1, 32'd5, 32'd6);
    repeat (8) begin
      @(posedge CLK);
      #1;
    end
    op    = 3'd2;
    srcA  = 32'd100;
    srcB  = 32'd7;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    chk("busy_ignored_start", 64'(busy), 64'h1);

    issue(3'd0, 32'd2, 32'd3);
    repeat (13) begin
      @(posedge CLK);
      #1;
    end
    RESETn = 1'b0;
    #1;
    chk("midop_reset_hi", 64'(hi), 64'h0);
    chk("midop_reset_lo", 64'(lo), 64'h0);
    chk("midop_reset_busy", 64'(busy), 64'h0);
    sb.delete();
    mhi = '0;
    mlo = '0;
    @(posedge CLK);
    #1;
    RESETn = 1'b1;

    issue(3'd4, 32'hCAFE_BABE, 32'd0);
    issue(3'd5, 32'h0000_0001, 32'd0);
    issue(3'd7, 32'd2, 32'd3);
    issue(3'd6, 32'hFFFF_FFFE, 32'd3);

    for (int i = 0; i < 120; i++)
      issue(3'($urandom_range(0, 7)), pick(), pick());

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending %0d", sb.size());
    end
    @(posedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
